// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: state encoding and default widths.
// REGFILE_ARB_RR_EN selects round-robin arbitration; without it the arbiter is fixed priority.
package regfile_write_arbiter_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned AW         = 3;
  localparam int unsigned LOCK_CNT_W = 4;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    StIdle   = ST_IDLE,
    StLocked = ST_LOCKED
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first eligible index at or after the pointer wins.
// The result is one-hot, or all-zero when nothing is eligible.
module regfile_write_arbiter_rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner
);

  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(pointer) + k) % N;
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-write-port arbiter for the register bank with bounded locked ownership.
// Define REGFILE_ARB_RR_EN for round-robin; otherwise the lowest eligible index wins.
module regfile_write_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned NREG     = 8,
  parameter int unsigned AW       = regfile_write_arbiter_pkg::AW,
  parameter int unsigned DW       = regfile_write_arbiter_pkg::DW,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      reg_en,
  output logic [DW-1:0]        reg_d,
  output logic                 owner_locked
);

  import regfile_write_arbiter_pkg::*;

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LOCK_CNT_W-1:0] LockMax = LOCK_CNT_W'(LOCK_MAX);
  localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]       ign_q, ign_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREG-1:0]       reg_en_q, reg_en_d;
  logic [DW-1:0]         reg_d_q, reg_d_d;

  logic [NREQ-1:0] eligible, pick;
  logic [PW-1:0]   pick_idx, win_idx, ptr;
  logic            win_vld;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i] = addr[i*AW +: AW];
      data_a[i] = data[i*DW +: DW];
    end
  end

  // A requester still seeing its own gnt is masked so a held req is not granted twice.
  assign eligible = req & ~gnt_q;

  regfile_write_arbiter_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .eligible (eligible),
    .pointer  (ptr),
    .winner   (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ign_d   = ign_q;
    win_vld = 1'b0;
    win_idx = '0;
    unique case (state_q)
      StIdle: begin
        if (|pick) begin
          win_vld         = 1'b1;
          win_idx         = pick_idx;
          ign_d[pick_idx] = 1'b0;
          if (lock[pick_idx] && !ign_q[pick_idx]) begin
            state_d = StLocked;
            owner_d = pick_idx;
            cnt_d   = LOCK_CNT_W'(1);
          end
        end
      end
      StLocked: begin
        if (cnt_q == LockMax) begin
          // Forced release: the owner's next win is treated as unlocked.
          state_d        = StIdle;
          cnt_d          = '0;
          ign_d[owner_q] = 1'b1;
        end else if (req[owner_q]) begin
          win_vld = 1'b1;
          win_idx = owner_q;
          if (lock[owner_q]) begin
            cnt_d = cnt_q + LOCK_CNT_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    reg_en_d = '0;
    reg_d_d  = reg_d_q;
    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      reg_en_d       = NREG'(1) << addr_a[win_idx];
      reg_d_d        = data_a[win_idx];
    end
  end

`ifdef REGFILE_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) ptr_d = (win_idx == LastIdx) ? '0 : win_idx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      cnt_q    <= '0;
      ign_q    <= '0;
      gnt_q    <= '0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      ign_q    <= ign_d;
      gnt_q    <= gnt_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
    end
  end

  assign gnt          = gnt_q;
  assign reg_en       = reg_en_q;
  assign reg_d        = reg_d_q;
  assign owner_locked = (state_q == StLocked);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random stimulus against a cycle-level model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int NREQ     = 3;
  localparam int NREG     = 8;
  localparam int AW       = 3;
  localparam int DW       = 16;
  localparam int LOCK_MAX = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      reg_en;
  logic [DW-1:0]        reg_d;
  logic                 owner_locked;

  regfile_write_arbiter #(
    .NREQ     (NREQ),
    .NREG     (NREG),
    .AW       (AW),
    .DW       (DW),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .addr         (addr),
    .data         (data),
    .gnt          (gnt),
    .reg_en       (reg_en),
    .reg_d        (reg_d),
    .owner_locked (owner_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: who owns the port, how many beats it has had, where the search starts.
  bit              m_locked;
  int              m_owner;
  int              m_beats;
  int              m_ptr;
  bit              m_ign [NREQ];
  logic [NREQ-1:0] m_gnt;
  logic [NREG-1:0] m_en;
  logic [DW-1:0]   m_d;

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_ptr    = 0;
    for (int i = 0; i < NREQ; i++) m_ign[i] = 1'b0;
    m_gnt = '0;
    m_en  = '0;
    m_d   = '0;
  endtask

  task automatic model_edge();
    int              w;
    int              cand;
    logic [NREQ-1:0] granted_last;
    w = -1;
    granted_last = m_gnt;
    if (m_locked) begin
      if (m_beats == LOCK_MAX) begin
        m_locked       = 1'b0;
        m_ign[m_owner] = 1'b1;
      end else if (req[m_owner]) begin
        w = m_owner;
        if (lock[m_owner]) m_beats = m_beats + 1;
        else               m_locked = 1'b0;
      end else begin
        m_locked = 1'b0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef REGFILE_ARB_RR_EN
        cand = (m_ptr + k) % NREQ;
`else
        cand = k;
`endif
        if (w < 0 && req[cand] && !granted_last[cand]) w = cand;
      end
      if (w >= 0) begin
        if (lock[w] && !m_ign[w]) begin
          m_locked = 1'b1;
          m_owner  = w;
          m_beats  = 1;
        end
        m_ign[w] = 1'b0;
      end
    end
    m_gnt = '0;
    m_en  = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_en[addr[w*AW +: AW]] = 1'b1;
      m_d   = data[w*DW +: DW];
      m_ptr = (w + 1) % NREQ;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
    chk({tag, ".reg_en"}, 32'(reg_en), 32'(m_en));
    chk({tag, ".reg_d"}, 32'(reg_d), 32'(m_d));
    chk({tag, ".owner_locked"}, 32'(owner_locked), 32'(m_locked));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
  endtask

  task automatic new_data();
    data = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  initial begin
    rst  = 1'b0;
    req  = 3'b111;
    lock = 3'b000;
    addr = {3'd5, 3'd2, 3'd1};
    new_data();
    model_reset();
    #1;
    check_all("reset_async");
    for (int n = 0; n < 3; n++) step("reset_hold");
    chk("reset.gnt_zero", 32'(gnt), 32'd0);
    rst = 1'b1;

    // Held requests with distinct addresses: grant order and enable decode.
    for (int n = 0; n < 8; n++) begin
      step("rotate");
      new_data();
    end

    // A single held request must never be granted on back-to-back cycles.
    req = 3'b001;
    for (int n = 0; n < 6; n++) step("dbl_guard");

    // Locked burst from requester 1 with requester 0 waiting.
    req  = 3'b011;
    lock = 3'b010;
    for (int n = 0; n < 10; n++) begin
      step("lock");
      new_data();
    end

    // Reset in the middle of a locked burst.
    req  = 3'b010;
    lock = 3'b010;
    step("prelock_a");
    step("prelock_b");
    step("prelock_c");
    mid_reset("midlock_rst");
    step("midlock_hold");
    rst  = 1'b1;
    req  = 3'b111;
    lock = 3'b000;
    for (int n = 0; n < 4; n++) step("post_rst");

    // Randomised traffic with heavy locking and occasional resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i]  = ($urandom_range(3) != 0);
        lock[i] = ($urandom_range(4) != 0);
      end
      addr = 9'($urandom);
      new_data();
      if ($urandom_range(80) == 0) begin
        mid_reset("rand_rst");
        step("rand_rst_hold");
        rst = 1'b1;
      end else begin
        step("random");
      end
    end

    // Requesters 1 and 2 held with no lock.
    req  = 3'b110;
    lock = 3'b000;
    for (int n = 0; n < 8; n++) step("pair_held");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
